// File: rtl/inst_fetch_unit.sv
// Front-end fetch stage: holds the PC, fetches words via the memory controller and pushes {inst, pc}.
// Optional direct-mapped I-cache enabled by defining ICACHE_EN.
module inst_fetch_unit #(
  parameter int ADDR_W       = 32,
  parameter int INST_W       = 32,
  parameter int ICACHE_IDX_W = 6
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              rob_flush_in,
  input  logic [ADDR_W-1:0] rob_target_pc_in,
  input  logic              instqueue_rdy_in,
  output logic              instqueue_en_out,
  output logic [INST_W-1:0] instqueue_inst_out,
  output logic [ADDR_W-1:0] instqueue_pc_out,
  output logic              memctrl_req_out,
  output logic [ADDR_W-1:0] memctrl_addr_out,
  input  logic              memctrl_valid_in,
  input  logic [INST_W-1:0] memctrl_inst_in
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic              en_nxt, req_nxt;
  logic [INST_W-1:0] inst_nxt;
  logic [ADDR_W-1:0] pc_out_nxt, addr_nxt;
  logic              hit;
  logic [INST_W-1:0] hit_data;

  if (ICACHE_IDX_W < 1 || ICACHE_IDX_W > ADDR_W - 3) begin : g_bad_idx_w
    $error("inst_fetch_unit: ICACHE_IDX_W out of range");
  end

`ifdef ICACHE_EN
  localparam int LINES = 1 << ICACHE_IDX_W;
  localparam int TAG_W = ADDR_W - ICACHE_IDX_W - 2;

  logic [LINES-1:0]        line_valid;
  logic [TAG_W-1:0]        line_tag  [LINES];
  logic [INST_W-1:0]       line_data [LINES];
  logic [ICACHE_IDX_W-1:0] rd_idx, wr_idx;
  logic                    fill;

  assign rd_idx   = pc[ICACHE_IDX_W+1:2];
  assign wr_idx   = memctrl_addr_out[ICACHE_IDX_W+1:2];
  assign hit      = line_valid[rd_idx] && (line_tag[rd_idx] == pc[ADDR_W-1:ICACHE_IDX_W+2]);
  assign hit_data = line_data[rd_idx];
  // Fill also happens on a flush-coincident return: address and data still match.
  assign fill     = rdy_in && (state == WAIT_MEM) && memctrl_valid_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      line_valid <= '0;
    end else if (fill) begin
      line_valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (fill) begin
      line_tag[wr_idx]  <= memctrl_addr_out[ADDR_W-1:ICACHE_IDX_W+2];
      line_data[wr_idx] <= memctrl_inst_in;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    en_nxt     = 1'b0;
    inst_nxt   = instqueue_inst_out;
    pc_out_nxt = instqueue_pc_out;
    req_nxt    = memctrl_req_out;
    addr_nxt   = memctrl_addr_out;
    if (rob_flush_in) begin
      pc_nxt    = {rob_target_pc_in[ADDR_W-1:2], 2'b00};
      req_nxt   = 1'b0;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (instqueue_rdy_in) begin
            if (hit) begin
              en_nxt     = 1'b1;
              inst_nxt   = hit_data;
              pc_out_nxt = pc;
              pc_nxt     = pc + ADDR_W'(4);
            end else begin
              req_nxt   = 1'b1;
              addr_nxt  = pc;
              state_nxt = WAIT_MEM;
            end
          end
        end
        WAIT_MEM: begin
          if (memctrl_valid_in) begin
            en_nxt     = 1'b1;
            inst_nxt   = memctrl_inst_in;
            pc_out_nxt = pc;
            pc_nxt     = pc + ADDR_W'(4);
            req_nxt    = 1'b0;
            state_nxt  = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state              <= IDLE;
      pc                 <= '0;
      instqueue_en_out   <= 1'b0;
      instqueue_inst_out <= '0;
      instqueue_pc_out   <= '0;
      memctrl_req_out    <= 1'b0;
      memctrl_addr_out   <= '0;
    end else if (rdy_in) begin
      state              <= state_nxt;
      pc                 <= pc_nxt;
      instqueue_en_out   <= en_nxt;
      instqueue_inst_out <= inst_nxt;
      instqueue_pc_out   <= pc_out_nxt;
      memctrl_req_out    <= req_nxt;
      memctrl_addr_out   <= addr_nxt;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: directed stimulus, memory responder, push monitor.
// Cache-hit expectations switch on ICACHE_EN.
module tb_inst_fetch_unit;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } push_t;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, qrdy;
  logic [31:0] target;
  logic        en;
  logic [31:0] inst, pco;
  logic        req;
  logic [31:0] addr;
  logic        mvalid = 1'b0;
  logic [31:0] minst  = '0;

  int    checks  = 0;
  int    errors  = 0;
  int    mem_lat = 3;
  int    cnt     = 0;
  push_t exp_q[$];
  push_t mon_e;
  logic [31:0] seq_inst [4] = '{32'h0000_0013, 32'hC0DE_0004, 32'hC0DE_0008, 32'hC0DE_000C};

  always #5 clk = ~clk;

  inst_fetch_unit #(.ADDR_W(32), .INST_W(32), .ICACHE_IDX_W(6)) dut (
    .clk_in             (clk),
    .rst_in             (rst),
    .rdy_in             (rdy),
    .rob_flush_in       (flush),
    .rob_target_pc_in   (target),
    .instqueue_rdy_in   (qrdy),
    .instqueue_en_out   (en),
    .instqueue_inst_out (inst),
    .instqueue_pc_out   (pco),
    .memctrl_req_out    (req),
    .memctrl_addr_out   (addr),
    .memctrl_valid_in   (mvalid),
    .memctrl_inst_in    (minst)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0000_0013 : (32'hC0DE_0000 | {16'h0, a[15:0]});
  endfunction

  // Memory responder: valid pulse once req has been seen for mem_lat enabled cycles.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst || !req) begin
        cnt    = 0;
        mvalid = 1'b0;
      end else if (!rdy) begin
        mvalid = 1'b0;
      end else begin
        cnt    = cnt + 1;
        mvalid = (cnt == mem_lat);
        minst  = mem_word(addr);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL push_unexpected: got inst=%h pc=%h, required no push", inst, pco);
      end else begin
        mon_e = exp_q.pop_front();
        if (inst !== mon_e.inst || pco !== mon_e.pc) begin
          errors++;
          $display("FAIL push_data: got inst=%h pc=%h, required inst=%h pc=%h",
                   inst, pco, mon_e.inst, mon_e.pc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic expect_push(input logic [31:0] i, input logic [31:0] p);
    exp_q.push_back({i, p});
  endtask

  task automatic wait_en(input string name, input int exp_n);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (en !== 1'b1 && n < 20);
    check({name, "_latency"}, n, exp_n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; target = '0; qrdy = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req",  req,  0);
    check("rst_en",   en,   0);
    check("rst_addr", addr, 0);
    check("rst_inst", inst, 0);
    check("rst_pc",   pco,  0);
    rst = 1'b0;

    @(negedge clk);
    check("first_req",  req,  1);
    check("first_addr", addr, 0);
    expect_push(32'h0000_0013, 32'h0);
    wait_en("first_fetch", 3);
    check("req_drop_on_push", req, 0);
    @(negedge clk);
    check("second_req",  req,  1);
    check("second_addr", addr, 32'h4);
    expect_push(32'hC0DE_0004, 32'h4);
    wait_en("second_fetch", 3);

    qrdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_req", req, 0);
    end
    qrdy = 1'b1;
    @(negedge clk);
    check("resume_req",  req,  1);
    check("resume_addr", addr, 32'h8);

    flush = 1'b1; target = 32'h1003;
    @(negedge clk);
    flush = 1'b0;
    check("flush_req", req, 0);
    check("flush_en",  en,  0);
    @(negedge clk);
    check("redirect_req",  req,  1);
    check("redirect_addr", addr, 32'h1000);
    expect_push(32'hC0DE_1000, 32'h1000);
    wait_en("redirect_fetch", 3);

    @(negedge clk);
    check("next_req",  req,  1);
    check("next_addr", addr, 32'h1004);
    repeat (2) @(negedge clk);
    check("pre_coincide_en", en, 0);
    flush = 1'b1; target = 32'hFFFF_FFFC;
    @(negedge clk);
    flush = 1'b0;
    check("coincide_en",  en,  0);
    check("coincide_req", req, 0);

    @(negedge clk);
    check("wrap_req",  req,  1);
    check("wrap_addr", addr, 32'hFFFF_FFFC);
    expect_push(32'hC0DE_FFFC, 32'hFFFF_FFFC);
    rdy = 1'b0; flush = 1'b1; target = 32'h40;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      flush = 1'b0;
      check("freeze_req",  req,  1);
      check("freeze_addr", addr, 32'hFFFF_FFFC);
      check("freeze_en",   en,   0);
    end
    rdy = 1'b1;
    wait_en("wrap_fetch", 3);

    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("seq_req",  req,  1);
      check("seq_addr", addr, 32'(k * 4));
      expect_push(seq_inst[k], 32'(k * 4));
      wait_en("seq_fetch", 3);
    end

    flush = 1'b1; target = 32'h0;
    @(negedge clk);
    flush = 1'b0;
    check("refetch_flush_req", req, 0);
    for (int k = 0; k < 4; k++) expect_push(seq_inst[k], 32'(k * 4));
`ifdef ICACHE_EN
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("hit_en",  en,  1);
      check("hit_req", req, 0);
    end
`else
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("miss_req",  req,  1);
      check("miss_addr", addr, 32'(k * 4));
      wait_en("miss_fetch", 3);
    end
`endif

    @(negedge clk);
    check("pre_reset_req",  req,  1);
    check("pre_reset_addr", addr, 32'h10);
    #3 rst = 1'b1;
    #1;
    check("async_rst_req", req, 0);
    check("async_rst_pc",  pco, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_req",  req,  1);
    check("post_reset_addr", addr, 32'h0);
    expect_push(32'h0000_0013, 32'h0);
    wait_en("post_reset_fetch", 3);

    qrdy = 1'b0;
    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
